// File: rtl/packetizer_ctrl.sv
// packetizer_ctrl
//   Forwards a sample stream to an AXI DMA S2MM port, cutting it into packets
//   of LEN beats with TLAST on the final beat of each packet. A run/stop state
//   machine (IDLE/RUN/DONE) gates the input; runs end after NPKT packets
//   (NPKT=0: continuous) or at the packet boundary following a STOP request.
//   The output is a single register slice (latency 1, full throughput).
//
// Ports
//   aclk, areset               clock, asynchronous active-high reset
//   s_axis_data_*              sample stream in (tdata/tvalid/tready)
//   m_axis_s2mm_*              packetised stream out (tdata/tvalid/tready/tlast)
//   last                       one-cycle pulse after a TLAST beat is taken downstream
//   s_axi_lite_*               AXI4-Lite register port:
//                                0x00 CTRL   W  bit0 START, bit1 STOP (reads 0)
//                                0x04 LEN    RW beats per packet
//                                0x08 NPKT   RW packets per run, 0 = continuous
//                                0x0C STATUS RO bit0 busy, bit1 done, bit2 stop_pending
//                                0x10 BEAT_CNT RO
//                                0x14 PKT_CNT  RO
module packetizer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,

  output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
  output logic                  m_axis_s2mm_tvalid,
  input  logic                  m_axis_s2mm_tready,
  output logic                  m_axis_s2mm_tlast,

  output logic                  last,

  input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic [2:0]            s_axi_lite_awprot,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [31:0]           s_axi_lite_wdata,
  input  logic [3:0]            s_axi_lite_wstrb,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  output logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic [2:0]            s_axi_lite_arprot,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  output logic [31:0]           s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-3:0] REG_CTRL   = (ADDR_WIDTH-2)'(0);
  localparam logic [ADDR_WIDTH-3:0] REG_LEN    = (ADDR_WIDTH-2)'(1);
  localparam logic [ADDR_WIDTH-3:0] REG_NPKT   = (ADDR_WIDTH-2)'(2);
  localparam logic [ADDR_WIDTH-3:0] REG_STATUS = (ADDR_WIDTH-2)'(3);
  localparam logic [ADDR_WIDTH-3:0] REG_BEAT   = (ADDR_WIDTH-2)'(4);
  localparam logic [ADDR_WIDTH-3:0] REG_PKT    = (ADDR_WIDTH-2)'(5);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   npkt_q;
  logic [CNT_WIDTH-1:0]   beat_cnt;
  logic [CNT_WIDTH-1:0]   pkt_cnt;
  logic                   stop_pending;

  logic                   in_hs;
  logic                   is_last;
  logic                   end_run;
  logic                   busy;

  logic                   aw_held;
  logic                   w_held;
  logic [ADDR_WIDTH-1:0]  aw_addr_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;

  logic                   wr_fire;
  logic [ADDR_WIDTH-3:0]  wr_idx;
  logic                   wr_err;
  logic                   wr_start;
  logic                   wr_stop;
  logic                   wr_len;
  logic                   wr_npkt;

  logic [ADDR_WIDTH-3:0]  rd_idx;
  logic [31:0]            rd_data;
  logic                   rd_err;

  logic                   unused_bits;

  assign unused_bits = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                         aw_addr_q[1:0], s_axi_lite_araddr[1:0]};

  // Byte-lane merge of a 32-bit write into a CNT_WIDTH register.
  function automatic logic [CNT_WIDTH-1:0] merge_bytes(
    input logic [CNT_WIDTH-1:0] old,
    input logic [31:0]          data,
    input logic [3:0]           strb
  );
    logic [31:0] o;
    o = '0;
    o[CNT_WIDTH-1:0] = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) o[i*8 +: 8] = data[i*8 +: 8];
    end
    return o[CNT_WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Stream datapath control
  // ---------------------------------------------------------------------
  assign busy               = (state == RUN) | m_axis_s2mm_tvalid;
  assign s_axis_data_tready = (state == RUN) & (!m_axis_s2mm_tvalid | m_axis_s2mm_tready);
  assign in_hs              = s_axis_data_tvalid & s_axis_data_tready;
  assign is_last            = (beat_cnt == len_q - CNT_ONE);

  // A STOP written in the same cycle as a packet's last beat closes the run
  // at that boundary, so the live write strobe is folded in here.
  assign end_run = in_hs & is_last &
                   (((npkt_q != '0) && ((pkt_cnt + CNT_ONE) == npkt_q)) ||
                    stop_pending || wr_stop);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state              <= IDLE;
      beat_cnt           <= '0;
      pkt_cnt            <= '0;
      stop_pending       <= 1'b0;
      m_axis_s2mm_tdata  <= '0;
      m_axis_s2mm_tvalid <= 1'b0;
      m_axis_s2mm_tlast  <= 1'b0;
      last               <= 1'b0;
    end else begin
      last <= m_axis_s2mm_tvalid & m_axis_s2mm_tready & m_axis_s2mm_tlast;

      if (in_hs) begin
        m_axis_s2mm_tdata  <= s_axis_data_tdata;
        m_axis_s2mm_tvalid <= 1'b1;
        m_axis_s2mm_tlast  <= is_last;
        beat_cnt           <= is_last ? '0 : beat_cnt + CNT_ONE;
        if (is_last && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + CNT_ONE;
      end else if (m_axis_s2mm_tready) begin
        m_axis_s2mm_tvalid <= 1'b0;
        m_axis_s2mm_tlast  <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (wr_start && (len_q != '0)) begin
            state        <= RUN;
            beat_cnt     <= '0;
            pkt_cnt      <= '0;
            stop_pending <= 1'b0;
          end
        end
        RUN: begin
          if (end_run) begin
            state        <= DONE;
            stop_pending <= 1'b0;
          end else if (wr_stop) begin
            stop_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // AXI4-Lite write decode
  // ---------------------------------------------------------------------
  assign wr_fire = aw_held & w_held & !s_axi_lite_bvalid;
  assign wr_idx  = aw_addr_q[ADDR_WIDTH-1:2];

  always_comb begin
    wr_err   = 1'b0;
    wr_start = 1'b0;
    wr_stop  = 1'b0;
    wr_len   = 1'b0;
    wr_npkt  = 1'b0;
    if (wr_fire) begin
      case (wr_idx)
        REG_CTRL: begin
          wr_start = w_data_q[0];
          wr_stop  = w_data_q[1];
        end
        REG_LEN: begin
          if (busy) wr_err = 1'b1;
          else      wr_len = 1'b1;
        end
        REG_NPKT: begin
          if (busy) wr_err  = 1'b1;
          else      wr_npkt = 1'b1;
        end
        default: wr_err = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // AXI4-Lite read decode
  // ---------------------------------------------------------------------
  assign rd_idx = s_axi_lite_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      REG_CTRL:   rd_data = '0;
      REG_LEN:    rd_data = 32'(len_q);
      REG_NPKT:   rd_data = 32'(npkt_q);
      REG_STATUS: rd_data = {29'd0, stop_pending, (state == DONE), busy};
      REG_BEAT:   rd_data = 32'(beat_cnt);
      REG_PKT:    rd_data = 32'(pkt_cnt);
      default:    rd_err  = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // AXI4-Lite channel handshakes. AW and W are captured independently and
  // the write is committed once both are held; ready is raised one cycle
  // after valid so it can reset to 0.
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s_axi_lite_awready <= 1'b0;
      s_axi_lite_wready  <= 1'b0;
      s_axi_lite_bvalid  <= 1'b0;
      s_axi_lite_bresp   <= RESP_OKAY;
      s_axi_lite_arready <= 1'b0;
      s_axi_lite_rvalid  <= 1'b0;
      s_axi_lite_rresp   <= RESP_OKAY;
      s_axi_lite_rdata   <= '0;
      aw_held            <= 1'b0;
      w_held             <= 1'b0;
      aw_addr_q          <= '0;
      w_data_q           <= '0;
      w_strb_q           <= '0;
      len_q              <= '0;
      npkt_q             <= '0;
    end else begin
      if (s_axi_lite_awvalid && s_axi_lite_awready) begin
        s_axi_lite_awready <= 1'b0;
        aw_held            <= 1'b1;
        aw_addr_q          <= s_axi_lite_awaddr;
      end else if (s_axi_lite_awvalid && !s_axi_lite_awready && !aw_held &&
                   !s_axi_lite_bvalid) begin
        s_axi_lite_awready <= 1'b1;
      end

      if (s_axi_lite_wvalid && s_axi_lite_wready) begin
        s_axi_lite_wready <= 1'b0;
        w_held            <= 1'b1;
        w_data_q          <= s_axi_lite_wdata;
        w_strb_q          <= s_axi_lite_wstrb;
      end else if (s_axi_lite_wvalid && !s_axi_lite_wready && !w_held &&
                   !s_axi_lite_bvalid) begin
        s_axi_lite_wready <= 1'b1;
      end

      if (wr_fire) begin
        aw_held           <= 1'b0;
        w_held            <= 1'b0;
        s_axi_lite_bvalid <= 1'b1;
        s_axi_lite_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (wr_len)  len_q  <= merge_bytes(len_q,  w_data_q, w_strb_q);
        if (wr_npkt) npkt_q <= merge_bytes(npkt_q, w_data_q, w_strb_q);
      end else if (s_axi_lite_bvalid && s_axi_lite_bready) begin
        s_axi_lite_bvalid <= 1'b0;
      end

      if (s_axi_lite_arvalid && s_axi_lite_arready) begin
        s_axi_lite_arready <= 1'b0;
        s_axi_lite_rvalid  <= 1'b1;
        s_axi_lite_rdata   <= rd_data;
        s_axi_lite_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (s_axi_lite_arvalid && !s_axi_lite_arready && !s_axi_lite_rvalid)
          s_axi_lite_arready <= 1'b1;
        if (s_axi_lite_rvalid && s_axi_lite_rready)
          s_axi_lite_rvalid <= 1'b0;
      end
    end
  end

endmodule
